// File: rtl/dff_pipe_bank.sv
// dff_pipe_bank: WIDTH-bit, DEPTH-stage register bank with per-stage valid
// tags, clock enable, valid flush, occupancy count and a full scan chain.
// All outputs come straight from flops; the capture edge is chosen by CLK_POL.
module dff_pipe_bank #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter bit               CLK_POL   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN,
  input  logic                       FLUSH,
  input  logic [WIDTH-1:0]           D,
  input  logic                       DV,
  input  logic                       SE,
  input  logic                       SI,
  output logic [WIDTH-1:0]           Q,
  output logic                       QV,
  output logic                       SO,
  output logic [$clog2(DEPTH+1)-1:0] OCC
);

  localparam int NBITS = WIDTH * DEPTH;
  localparam int OCC_W = $clog2(DEPTH + 1);

  // Stage i occupies flat bits [i*WIDTH +: WIDTH], so the flat vector is the
  // scan chain order: s0.b0 is bit 0 and s[DEPTH-1].b[WIDTH-1] is the top bit.
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d;
  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            valid_d;
  logic [OCC_W-1:0]            occ_q;
  logic [OCC_W-1:0]            occ_d;
  logic [NBITS-1:0]            data_flat;
  logic [NBITS-1:0]            scan_flat;

  assign data_flat = data_q;

  // Scan shift: every bit moves one place up the chain, SI enters at s0.b0.
  always_comb begin
    scan_flat    = '0;
    scan_flat[0] = SI;
    for (int k = 1; k < NBITS; k++) begin
      scan_flat[k] = data_flat[k-1];
    end
  end

  // Next-state selection for the non-reset cases: scan, then flush, then
  // enable, otherwise a full hold of data, valids and occupancy.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    occ_d   = occ_q;
    if (SE) begin
      data_d = scan_flat;
    end else if (FLUSH) begin
      valid_d = '0;
      occ_d   = '0;
    end else if (EN) begin
      data_d[0]  = D;
      valid_d[0] = DV;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // A tag entering at stage 0 counts up, the one leaving the last stage
      // drops out; modular wrap of the intermediate sum cancels out.
      occ_d = occ_q + OCC_W'(DV) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  generate
    if (CLK_POL) begin : g_pos_edge
      // State register on the rising edge; reset overrides everything else.
      always_ff @(posedge CLK) begin
        if (RST) begin
          data_q  <= {DEPTH{RESET_VAL}};
          valid_q <= '0;
          occ_q   <= '0;
        end else begin
          data_q  <= data_d;
          valid_q <= valid_d;
          occ_q   <= occ_d;
        end
      end
    end else begin : g_neg_edge
      // State register on the falling edge; reset overrides everything else.
      always_ff @(negedge CLK) begin
        if (RST) begin
          data_q  <= {DEPTH{RESET_VAL}};
          valid_q <= '0;
          occ_q   <= '0;
        end else begin
          data_q  <= data_d;
          valid_q <= valid_d;
          occ_q   <= occ_d;
        end
      end
    end
  endgenerate

  assign Q   = data_q[DEPTH-1];
  assign QV  = valid_q[DEPTH-1];
  assign SO  = data_q[DEPTH-1][WIDTH-1];
  assign OCC = occ_q;

endmodule

// File: tb/tb_dff_pipe_bank.sv
// tb_dff_pipe_bank: table-driven vectors with a scoreboard queue for the
// default posedge bank, plus hand sequences for the RESET_VAL=8'hA5 variant,
// the 24-bit scan chain and the falling-edge variant.
module tb_dff_pipe_bank;

  typedef struct {
    logic       rst;
    logic       se;
    logic       flush;
    logic       en;
    logic       dv;
    logic       si;
    logic [7:0] d;
    logic [7:0] q;
    logic       qv;
    logic [1:0] occ;
    logic       so;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0, se = 1'b0, flush = 1'b0, en = 1'b0, dv = 1'b0, si = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] q, q_a;
  logic       qv, so, qv_a, so_a;
  logic [1:0] occ, occ_a;

  logic       n_rst = 1'b0, n_se = 1'b0, n_flush = 1'b0, n_en = 1'b0, n_dv = 1'b0, n_si = 1'b0;
  logic [7:0] n_d = 8'h00;
  logic [7:0] n_q;
  logic       n_qv, n_so;
  logic [1:0] n_occ;

  int total = 0;
  int bad   = 0;

  vec_t vecs[23];
  vec_t nvecs[7];
  vec_t sb[$];
  logic sb_so[$];

  always #5 clk = ~clk;

  dff_pipe_bank #(.WIDTH(8), .DEPTH(3), .CLK_POL(1'b1), .RESET_VAL(8'h00)) dut (
    .CLK(clk), .RST(rst), .EN(en), .FLUSH(flush), .D(d), .DV(dv), .SE(se), .SI(si),
    .Q(q), .QV(qv), .SO(so), .OCC(occ)
  );

  dff_pipe_bank #(.WIDTH(8), .DEPTH(3), .CLK_POL(1'b1), .RESET_VAL(8'hA5)) dut_a5 (
    .CLK(clk), .RST(rst), .EN(en), .FLUSH(flush), .D(d), .DV(dv), .SE(se), .SI(si),
    .Q(q_a), .QV(qv_a), .SO(so_a), .OCC(occ_a)
  );

  dff_pipe_bank #(.WIDTH(8), .DEPTH(3), .CLK_POL(1'b0), .RESET_VAL(8'h00)) dut_neg (
    .CLK(clk), .RST(n_rst), .EN(n_en), .FLUSH(n_flush), .D(n_d), .DV(n_dv), .SE(n_se), .SI(n_si),
    .Q(n_q), .QV(n_qv), .SO(n_so), .OCC(n_occ)
  );

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic e,
                              input logic v, input logic i, input logic [7:0] dd,
                              input logic [7:0] eq, input logic eqv, input logic [1:0] eocc,
                              input logic eso);
    vec_t t;
    t.rst = r; t.se = s; t.flush = f; t.en = e; t.dv = v; t.si = i; t.d = dd;
    t.q = eq; t.qv = eqv; t.occ = eocc; t.so = eso;
    return t;
  endfunction

  task automatic check_field(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s idx=%0d actual=%0h required=%0h", name, idx, act, req);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst; se = v.se; flush = v.flush; en = v.en; dv = v.dv; si = v.si; d = v.d;
    sb.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty idx=%0d actual=0 required=1", idx);
    end else begin
      e = sb.pop_front();
      check_field("q",   idx, 32'(q),   32'(e.q));
      check_field("qv",  idx, 32'(qv),  32'(e.qv));
      check_field("occ", idx, 32'(occ), 32'(e.occ));
      check_field("so",  idx, 32'(so),  32'(e.so));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] pat;
    vec_t        last;
    vec_t        e;

    //            rst se fl en dv si d       q      qv occ    so
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 2'd0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 1, 0, 8'h11, 8'h00, 0, 2'd1, 0);
    vecs[2]  = mk(0, 0, 0, 1, 1, 0, 8'h22, 8'h00, 0, 2'd2, 0);
    vecs[3]  = mk(0, 0, 0, 1, 1, 0, 8'h33, 8'h11, 1, 2'd3, 0);
    vecs[4]  = mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h22, 1, 2'd2, 0);
    vecs[5]  = mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h33, 1, 2'd1, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 2'd0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 1, 0, 8'h81, 8'h00, 0, 2'd1, 0);
    vecs[8]  = mk(0, 0, 0, 1, 1, 0, 8'h42, 8'h00, 0, 2'd2, 0);
    vecs[9]  = mk(0, 0, 0, 1, 1, 0, 8'hC4, 8'h81, 1, 2'd3, 1);
    vecs[10] = mk(0, 0, 0, 0, 1, 1, 8'hFF, 8'h81, 1, 2'd3, 1);
    vecs[11] = mk(0, 0, 0, 0, 1, 1, 8'hFF, 8'h81, 1, 2'd3, 1);
    vecs[12] = mk(0, 0, 0, 0, 1, 1, 8'hFF, 8'h81, 1, 2'd3, 1);
    vecs[13] = mk(0, 0, 0, 0, 1, 1, 8'hFF, 8'h81, 1, 2'd3, 1);
    vecs[14] = mk(0, 0, 0, 0, 1, 1, 8'hFF, 8'h81, 1, 2'd3, 1);
    vecs[15] = mk(0, 0, 1, 1, 1, 0, 8'hFF, 8'h81, 0, 2'd0, 1);
    vecs[16] = mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h42, 0, 2'd0, 0);
    vecs[17] = mk(1, 1, 1, 1, 1, 1, 8'hFF, 8'h00, 0, 2'd0, 0);
    vecs[18] = mk(0, 0, 0, 1, 1, 0, 8'h01, 8'h00, 0, 2'd1, 0);
    vecs[19] = mk(0, 0, 0, 1, 1, 0, 8'h02, 8'h00, 0, 2'd2, 0);
    vecs[20] = mk(0, 0, 0, 1, 1, 0, 8'h80, 8'h01, 1, 2'd3, 0);
    vecs[21] = mk(0, 1, 1, 1, 0, 1, 8'h00, 8'h02, 1, 2'd3, 0);
    vecs[22] = mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h05, 1, 2'd2, 0);

    nvecs[0] = mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 2'd0, 0);
    nvecs[1] = mk(0, 0, 0, 1, 1, 0, 8'h11, 8'h00, 0, 2'd1, 0);
    nvecs[2] = mk(0, 0, 0, 1, 1, 0, 8'h22, 8'h00, 0, 2'd2, 0);
    nvecs[3] = mk(0, 0, 0, 1, 1, 0, 8'h33, 8'h11, 1, 2'd3, 0);
    nvecs[4] = mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h22, 1, 2'd2, 0);
    nvecs[5] = mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h33, 1, 2'd1, 0);
    nvecs[6] = mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 2'd0, 0);

    $display("[TB] table vectors on posedge bank");
    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
      if (i == 0) begin
        check_field("a5_q",   i, 32'(q_a),   32'h0000_00A5);
        check_field("a5_so",  i, 32'(so_a),  32'd1);
        check_field("a5_qv",  i, 32'(qv_a),  32'd0);
        check_field("a5_occ", i, 32'(occ_a), 32'd0);
      end
    end

    $display("[TB] scan chain 24 bits in, 24 bits out");
    pat = 24'hC35AF0;
    for (int e2 = 1; e2 <= 47; e2++) begin
      @(negedge clk);
      rst = 1'b0; se = 1'b1; flush = 1'b0; en = 1'b1; dv = 1'b1; d = 8'hFF;
      if (e2 <= 24) begin
        si = pat[e2-1];
        sb_so.push_back(pat[e2-1]);
      end else begin
        si = 1'b0;
      end
      @(posedge clk);
      #1;
      check_field("scan_qv",  e2, 32'(qv),  32'd1);
      check_field("scan_occ", e2, 32'(occ), 32'd2);
      if (e2 == 24) begin
        check_field("scan_q_full", e2, 32'(q), 32'h0000_000F);
      end
      if (e2 >= 24) begin
        if (sb_so.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL scan_sb_empty idx=%0d actual=0 required=1", e2);
        end else begin
          check_field("scan_so", e2, 32'(so), 32'(sb_so.pop_front()));
        end
      end
    end
    @(negedge clk);
    se = 1'b0; en = 1'b0; si = 1'b0; dv = 1'b0;

    $display("[TB] falling-edge bank");
    last = nvecs[0];
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) begin
        e = sb.pop_front();
        check_field("neg_q",   i, 32'(n_q),   32'(e.q));
        check_field("neg_qv",  i, 32'(n_qv),  32'(e.qv));
        check_field("neg_occ", i, 32'(n_occ), 32'(e.occ));
        check_field("neg_so",  i, 32'(n_so),  32'(e.so));
        last = e;
      end
      if (i < 7) begin
        n_rst = nvecs[i].rst; n_se = nvecs[i].se; n_flush = nvecs[i].flush;
        n_en = nvecs[i].en; n_dv = nvecs[i].dv; n_si = nvecs[i].si; n_d = nvecs[i].d;
        sb.push_back(nvecs[i]);
      end
      @(posedge clk);
      #1;
      if (i > 0) begin
        check_field("neg_hold_q",   i, 32'(n_q),   32'(last.q));
        check_field("neg_hold_occ", i, 32'(n_occ), 32'(last.occ));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
